// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory controller.
// Device addresses are absolute for the standard window; offsets are derived from them.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        IO_ACC    = 2'd1,
        SRAM_WAIT = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_IO_BASE = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR       = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR       = 16'hFE02;
    localparam logic [15:0] DSR_ADDR        = 16'hFE04;
    localparam logic [15:0] DDR_ADDR        = 16'hFE06;

    localparam int READY_BIT = 15;
    localparam int IE_BIT    = 14;

    function automatic logic [15:0] io_offset(input logic [15:0] addr, input logic [15:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/lc3_io_regs.sv
// LC-3 memory-mapped keyboard and display registers with a single-cycle access port.
// DSR ready is the inverse of the pending display character, so the two can never disagree.
module lc3_io_regs
    import lc3_mem_pkg::*;
#(
    parameter logic [15:0] IO_BASE = DEFAULT_IO_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ie,
    output logic        dd_valid,
    output logic [7:0]  dd_data,
    input  logic        dd_ready
);

    localparam logic [15:0] KBSR_OFS = KBSR_ADDR - DEFAULT_IO_BASE;
    localparam logic [15:0] KBDR_OFS = KBDR_ADDR - DEFAULT_IO_BASE;
    localparam logic [15:0] DSR_OFS  = DSR_ADDR - DEFAULT_IO_BASE;
    localparam logic [15:0] DDR_OFS  = DDR_ADDR - DEFAULT_IO_BASE;

    logic        kb_ready_r;
    logic        kb_ie_r;
    logic [7:0]  kb_char_r;
    logic        dd_valid_r;
    logic [7:0]  dd_data_r;

    logic [15:0] ofs_s;
    logic        kbdr_rd_s;
    logic        kbsr_wr_s;
    logic        ddr_wr_s;
    logic        kb_load_s;

    // Address decode, read mux and access strobes.
    always_comb begin
        ofs_s    = io_offset(io_addr, IO_BASE);
        io_rdata = 16'h0000;
        case (ofs_s)
            KBSR_OFS: begin
                io_rdata[READY_BIT] = kb_ready_r;
                io_rdata[IE_BIT]    = kb_ie_r;
            end
            KBDR_OFS: io_rdata = {8'h00, kb_char_r};
            DSR_OFS:  io_rdata[READY_BIT] = ~dd_valid_r;
            default:  io_rdata = 16'h0000;
        endcase
        kbdr_rd_s = io_en && !io_we && (ofs_s == KBDR_OFS);
        kbsr_wr_s = io_en && io_we && (ofs_s == KBSR_OFS);
        ddr_wr_s  = io_en && io_we && (ofs_s == DDR_OFS) && !dd_valid_r;
        // A key arriving while KBDR is being read replaces the character just consumed.
        kb_load_s = kb_valid && (!kb_ready_r || kbdr_rd_s);
    end

    // Keyboard and display register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_ready_r <= 1'b0;
            kb_ie_r    <= 1'b0;
            kb_char_r  <= 8'h00;
            dd_valid_r <= 1'b0;
            dd_data_r  <= 8'h00;
        end else begin
            if (kb_load_s) begin
                kb_char_r  <= kb_data;
                kb_ready_r <= 1'b1;
            end else if (kbdr_rd_s) begin
                kb_ready_r <= 1'b0;
            end
            if (kbsr_wr_s) begin
                kb_ie_r <= io_wdata[IE_BIT];
            end
            if (ddr_wr_s) begin
                dd_valid_r <= 1'b1;
                dd_data_r  <= io_wdata[7:0];
            end else if (dd_valid_r && dd_ready) begin
                dd_valid_r <= 1'b0;
            end
        end
    end

    assign kb_ie    = kb_ie_r;
    assign dd_valid = dd_valid_r;
    assign dd_data  = dd_data_r;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: routes MAR/MDR accesses to external SRAM or device registers
// and returns a one-cycle ready pulse; SRAM accesses abort after SRAM_TIMEOUT cycles.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int          SRAM_TIMEOUT = 16,
    parameter logic [15:0] IO_BASE      = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_rw,
    input  logic [15:0] mar,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        mem_r,
    output logic        bus_err,
    output logic        sram_req,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic        sram_ack,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ie,
    output logic        dd_valid,
    output logic [7:0]  dd_data,
    input  logic        dd_ready
);

    localparam int CNT_W = $clog2(SRAM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SRAM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_TIMEOUT - 1);

    state_t           state_r;
    logic [15:0]      addr_r;
    logic [15:0]      wdata_r;
    logic             rw_r;
    logic [CNT_W-1:0] cnt_r;
    logic             io_en_s;
    logic [15:0]      io_rdata_s;

    assign io_en_s = (state_r == IO_ACC);

    lc3_io_regs #(
        .IO_BASE (IO_BASE)
    ) u_io_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_en    (io_en_s),
        .io_we    (rw_r),
        .io_addr  (addr_r),
        .io_wdata (wdata_r),
        .io_rdata (io_rdata_s),
        .kb_valid (kb_valid),
        .kb_data  (kb_data),
        .kb_ie    (kb_ie),
        .dd_valid (dd_valid),
        .dd_data  (dd_data),
        .dd_ready (dd_ready)
    );

    // Access FSM with registered SRAM-side and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            addr_r     <= 16'h0000;
            wdata_r    <= 16'h0000;
            rw_r       <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            rdata      <= 16'h0000;
            mem_r      <= 1'b0;
            bus_err    <= 1'b0;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= 16'h0000;
            sram_wdata <= 16'h0000;
        end else begin
            mem_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mem_en) begin
                        addr_r  <= mar;
                        rw_r    <= mem_rw;
                        wdata_r <= wdata;
                        if (mar >= IO_BASE) begin
                            state_r <= IO_ACC;
                        end else begin
                            state_r    <= SRAM_WAIT;
                            sram_req   <= 1'b1;
                            sram_we    <= mem_rw;
                            sram_addr  <= mar;
                            sram_wdata <= wdata;
                            cnt_r      <= {CNT_W{1'b0}};
                        end
                    end
                end
                IO_ACC: begin
                    if (!rw_r) begin
                        rdata <= io_rdata_s;
                    end
                    mem_r   <= 1'b1;
                    state_r <= DONE;
                end
                SRAM_WAIT: begin
                    if (sram_ack) begin
                        if (!rw_r) begin
                            rdata <= sram_rdata;
                        end
                        sram_req <= 1'b0;
                        sram_we  <= 1'b0;
                        mem_r    <= 1'b1;
                        state_r  <= DONE;
                    end else if (cnt_r >= CNT_LAST) begin
                        // Counter would reach SRAM_TIMEOUT this edge: abort.
                        if (!rw_r) begin
                            rdata <= 16'h0000;
                        end
                        sram_req <= 1'b0;
                        sram_we  <= 1'b0;
                        bus_err  <= 1'b1;
                        mem_r    <= 1'b1;
                        state_r  <= DONE;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    if (!mem_en) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory controller between the datapath MAR/MDR and off-datapath storage.
- Decodes each access from the control unit (mem_en, mem_rw) to either an external synchronous SRAM or the LC-3 memory-mapped device registers: KBSR, KBDR, DSR, DDR.
- Returns a one-cycle ready pulse (the LC-3 "R" signal), so the control unit waits on completion instead of counting fixed clocks.

Parameters:
- SRAM_TIMEOUT, 16: maximum cycles to wait for sram_ack before aborting the access.
- IO_BASE, 16'hFE00: lowest address of the device-register window (window is IO_BASE..16'hFFFF).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_en  in  1  access request from control; held high until mem_r.
- mem_rw  in  1  0 = read, 1 = write; sampled with mem_en.
- mar  in  16  access address.
- wdata  in  16  write data (MDR contents).
- rdata  out  16  read data to MDR; held until next completed read.
- mem_r  out  1  one-cycle completion pulse.
- bus_err  out  1  sticky; set on SRAM timeout.
- sram_req  out  1  SRAM request; held until ack.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  16  SRAM address.
- sram_wdata  out  16  SRAM write data.
- sram_rdata  in  16  SRAM read data; valid with sram_ack.
- sram_ack  in  1  SRAM completion, one cycle.
- kb_valid  in  1  keystroke strobe.
- kb_data  in  8  keystroke character.
- kb_ie  out  1  KBSR[14] interrupt-enable bit.
- dd_valid  out  1  display character valid.
- dd_data  out  8  display character.
- dd_ready  in  1  display accepted character.

Behaviour:
- Reset (async, rst_n low): all outputs 0, except rdata = 16'h0000 and DSR[15] = 1 (display ready). FSM goes to IDLE. KBSR = 0, KBDR = 0, bus_err = 0, sram_req drops immediately. An access in flight at reset is abandoned with no mem_r.
- FSM states: IDLE, IO_ACC, SRAM_WAIT, DONE.
- IDLE:
  - If mem_en = 1, latch mar, mem_rw and wdata into internal registers.
  - If mar >= IO_BASE, go to IO_ACC.
  - Otherwise go to SRAM_WAIT, asserting sram_req, sram_we, sram_addr and sram_wdata from the next cycle.
- IO_ACC (exactly one cycle): perform the register access, pulse mem_r, go to DONE. Device latency is 2 cycles from mem_en to mem_r.
- SRAM_WAIT:
  - Outputs held stable.
  - On sram_ack: rdata <= sram_rdata (reads only), pulse mem_r, go to DONE.
  - Cycle counter starts at 0 on entry. If it reaches SRAM_TIMEOUT with no ack: drop sram_req, set bus_err, rdata <= 0 on reads, pulse mem_r, go to DONE.
  - Minimum SRAM latency is 2 cycles + SRAM ack delay.
- DONE: wait for mem_en = 0, then go to IDLE (four-phase handshake). mem_en held high in DONE never starts a second access.
- Device register map:
  - IO_BASE+0 KBSR: [15] ready, read-only; [14] IE, read/write; other bits read 0.
  - IO_BASE+2 KBDR: {8'h00, kb char}. Reading it clears KBSR[15].
  - IO_BASE+4 DSR: [15] display ready; read-only.
  - IO_BASE+6 DDR: writes only. If DSR[15] = 1: dd_data <= wdata[7:0], dd_valid = 1, DSR[15] = 0. Write ignored if DSR[15] = 0. Reads return 0.
  - Any other window address: reads 0, writes ignored, still completes in IO_ACC.
- Keyboard:
  - kb_valid with KBSR[15] = 0: latch kb_data, set KBSR[15].
  - kb_valid with KBSR[15] = 1: keystroke dropped; KBDR unchanged.
  - kb_valid in the same cycle as a KBDR read: the read returns the old character, then the new character is latched and KBSR[15] ends at 1.
- Display: dd_valid held until dd_ready, then dd_valid = 0 and DSR[15] = 1 on the next edge. Device registers update independently of FSM state.
- Widths: all addresses 16-bit unsigned compares. The timeout counter is $clog2(SRAM_TIMEOUT+1) bits and saturates.

Decomposition:
- Package lc3_mem_pkg holds:
  - FSM state enum (IDLE, IO_ACC, SRAM_WAIT, DONE).
  - Device address constants: KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR.
  - Bit-index constants: READY_BIT = 15, IE_BIT = 14.
- Sub-module lc3_io_regs holds KBSR/KBDR/DSR/DDR plus the keyboard and display handshakes, with a single-cycle read/write port. lc3_mem_ctrl holds the FSM and the SRAM side.

Test Plan:
- SRAM read, ack 3 cycles after req, mar = 16'h3000, sram_rdata = 16'h1234 -> rdata = 16'h1234, single mem_r pulse; sram_we stays 0; no second access while mem_en stays high.
- SRAM write, mar = 16'h4000, wdata = 16'hBEEF -> sram_we = 1, sram_addr = 16'h4000, sram_wdata = 16'hBEEF held until ack; mem_r 1 cycle after ack.
- No ack, SRAM_TIMEOUT = 16 -> mem_r 16 cycles after entering SRAM_WAIT; rdata = 0, bus_err = 1 and stays 1 through later good accesses.
- kb_valid with kb_data = 8'h41, then read KBSR -> 16'h8000; read KBDR -> 16'h0041; KBSR then reads 16'h0000. A second key 8'h42 before the KBDR read is dropped.
- Write DDR = 16'h0058 -> dd_valid = 1, dd_data = 8'h58, DSR reads 0. A second DDR write 16'h0059 is ignored. dd_ready -> DSR reads 16'h8000.
- rst_n low mid SRAM_WAIT -> sram_req = 0 at once; no mem_r; state IDLE, DSR = 16'h8000, bus_err = 0 after release.
